// File: rtl/bsg_manycore_wh_edge_concentrator.sv
// Wormhole edge concentrator: packet-atomic round-robin merge of num_in_p links onto one link,
// plus cid-steered return path. Optional BSG_MANYCORE_WH_CONC_CID_CHECK_EN drops bad-cid packets.
module bsg_manycore_wh_edge_concentrator #(
  parameter int unsigned wh_flit_width_p = 16,
  parameter int unsigned wh_cord_width_p = 5,
  parameter int unsigned wh_len_width_p  = 3,
  parameter int unsigned wh_cid_width_p  = 2,
  parameter int unsigned num_in_p        = 2,
  localparam int unsigned wh_link_sif_width_lp = wh_flit_width_p + 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_in_p*wh_link_sif_width_lp-1:0] in_link_sif_i,
  output logic [num_in_p*wh_link_sif_width_lp-1:0] in_link_sif_o,
  input  logic [wh_link_sif_width_lp-1:0]          out_link_sif_i,
  output logic [wh_link_sif_width_lp-1:0]          out_link_sif_o,
  output logic                                     cid_err_o
);

  localparam int unsigned FlitW  = wh_flit_width_p;
  localparam int unsigned LinkW  = wh_link_sif_width_lp;
  localparam int unsigned LenW   = wh_len_width_p;
  localparam int unsigned IdxW   = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int unsigned LenLsb = wh_cord_width_p;
  localparam int unsigned CidLsb = wh_cord_width_p + wh_len_width_p;

  // Link layout: {v, ready_and_rev, data}
  logic [num_in_p-1:0] w_in_v;
  logic [num_in_p-1:0] w_in_ready_rev;
  logic [FlitW-1:0]    w_in_data [num_in_p];

  for (genvar i = 0; i < num_in_p; i++) begin : g_unpack
    assign w_in_v[i]         = in_link_sif_i[i*LinkW + LinkW - 1];
    assign w_in_ready_rev[i] = in_link_sif_i[i*LinkW + FlitW];
    assign w_in_data[i]      = in_link_sif_i[i*LinkW +: FlitW];
  end

  logic             w_rin_v;
  logic             w_out_ready;
  logic [FlitW-1:0] w_rin_data;

  assign w_rin_v     = out_link_sif_i[LinkW-1];
  assign w_out_ready = out_link_sif_i[FlitW];
  assign w_rin_data  = out_link_sif_i[FlitW-1:0];

  function automatic logic [IdxW-1:0] f_next(input logic [IdxW-1:0] idx);
    return (int'(idx) == int'(num_in_p) - 1) ? '0 : idx + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Forward input FIFOs (two entries each)
  // ---------------------------------------------------------------------------------------------
  logic [FlitW-1:0]    r_fmem [num_in_p][2];
  logic [num_in_p-1:0] r_fwp;
  logic [num_in_p-1:0] r_frp;
  logic [1:0]          r_focc [num_in_p];
  logic [num_in_p-1:0] w_fready;
  logic [num_in_p-1:0] w_fhead_v;
  logic [num_in_p-1:0] w_fenq;
  logic [num_in_p-1:0] w_fyumi;
  logic [FlitW-1:0]    w_fhead [num_in_p];

  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      w_fready[i]  = (r_focc[i] != 2'd2) & ~reset_i;
      w_fhead_v[i] = (r_focc[i] != 2'd0) & ~reset_i;
      w_fhead[i]   = r_fmem[i][r_frp[i]];
      w_fenq[i]    = w_in_v[i] & w_fready[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fwp <= '0;
      r_frp <= '0;
      for (int i = 0; i < num_in_p; i++) r_focc[i] <= 2'd0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        if (w_fenq[i]) begin
          r_fmem[i][r_fwp[i]] <= w_in_data[i];
          r_fwp[i]            <= ~r_fwp[i];
        end
        if (w_fyumi[i]) r_frp[i] <= ~r_frp[i];
        r_focc[i] <= r_focc[i] + {1'b0, w_fenq[i]} - {1'b0, w_fyumi[i]};
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Forward arbiter and packet lock
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StBusy} fwd_st_e;

  fwd_st_e          r_fst, w_fst_nxt;
  logic [IdxW-1:0]  r_rr_ptr, w_rr_nxt;
  logic [IdxW-1:0]  r_lock, w_lock_nxt;
  logic [LenW-1:0]  r_fcnt, w_fcnt_nxt;
  logic [IdxW-1:0]  w_grant;
  logic             w_any;
  logic [IdxW-1:0]  w_fsel;
  logic             w_out_v;
  logic             w_fxfer;
  logic [FlitW-1:0] w_out_data;
  logic [LenW-1:0]  w_fhead_len;

  // Walk from the farthest offset down so the first valid head at or after rr_ptr wins.
  always_comb begin
    w_grant = r_rr_ptr;
    w_any   = 1'b0;
    for (int k = int'(num_in_p) - 1; k >= 0; k--) begin
      if (w_fhead_v[(int'(r_rr_ptr) + k) % int'(num_in_p)]) begin
        w_grant = IdxW'((int'(r_rr_ptr) + k) % int'(num_in_p));
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    w_fst_nxt  = r_fst;
    w_rr_nxt   = r_rr_ptr;
    w_lock_nxt = r_lock;
    w_fcnt_nxt = r_fcnt;
    w_fsel     = w_grant;
    w_out_v    = w_any;
    if (r_fst == StBusy) begin
      w_fsel  = r_lock;
      w_out_v = w_fhead_v[r_lock];
    end
    w_out_data       = w_fhead[w_fsel];
    w_fhead_len      = w_out_data[LenLsb +: LenW];
    w_fxfer          = w_out_v & w_out_ready;
    w_fyumi          = '0;
    w_fyumi[w_fsel]  = w_fxfer;
    unique case (r_fst)
      StIdle: begin
        if (w_fxfer) begin
          if (w_fhead_len == '0) begin
            w_rr_nxt = f_next(w_fsel);
          end else begin
            w_fst_nxt  = StBusy;
            w_lock_nxt = w_fsel;
            w_fcnt_nxt = w_fhead_len;
          end
        end
      end
      StBusy: begin
        if (w_fxfer) begin
          w_fcnt_nxt = r_fcnt - 1'b1;
          if (r_fcnt == LenW'(1)) begin
            w_fst_nxt = StIdle;
            w_rr_nxt  = f_next(r_lock);
          end
        end
      end
      default: w_fst_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fst    <= StIdle;
      r_rr_ptr <= '0;
      r_lock   <= '0;
      r_fcnt   <= '0;
    end else begin
      r_fst    <= w_fst_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_lock   <= w_lock_nxt;
      r_fcnt   <= w_fcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Reverse FIFO and steering
  // ---------------------------------------------------------------------------------------------
  logic [FlitW-1:0] r_rmem [2];
  logic             r_rwp;
  logic             r_rrp;
  logic [1:0]       r_rocc;
  logic             w_rready;
  logic             w_rhead_v;
  logic [FlitW-1:0] w_rhead;
  logic             w_renq;
  logic             w_ryumi;

  assign w_rready  = (r_rocc != 2'd2) & ~reset_i;
  assign w_rhead_v = (r_rocc != 2'd0) & ~reset_i;
  assign w_rhead   = r_rmem[r_rrp];
  assign w_renq    = w_rin_v & w_rready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rwp  <= 1'b0;
      r_rrp  <= 1'b0;
      r_rocc <= 2'd0;
    end else begin
      if (w_renq) begin
        r_rmem[r_rwp] <= w_rin_data;
        r_rwp         <= ~r_rwp;
      end
      if (w_ryumi) r_rrp <= ~r_rrp;
      r_rocc <= r_rocc + {1'b0, w_renq} - {1'b0, w_ryumi};
    end
  end

  typedef enum logic [0:0] {StRevIdle, StRevBusy} rev_st_e;

  rev_st_e             r_rst, w_rst_nxt;
  logic [IdxW-1:0]     r_rsel, w_rsel_nxt;
  logic                r_rdrop, w_rdrop_nxt;
  logic [LenW-1:0]     r_rcnt, w_rcnt_nxt;
  logic [IdxW-1:0]     w_hdr_sel;
  logic [LenW-1:0]     w_hdr_len;
  logic                w_hdr_bad;
  logic [IdxW-1:0]     w_rsel;
  logic                w_rbad;
  logic                w_rsel_ready;
  logic [num_in_p-1:0] w_rev_v;

  assign w_hdr_sel = w_rhead[CidLsb +: IdxW];
  assign w_hdr_len = w_rhead[LenLsb +: LenW];

`ifdef BSG_MANYCORE_WH_CONC_CID_CHECK_EN
  logic [wh_cid_width_p-1:0] w_hdr_cid;
  logic                      r_cid_err;

  assign w_hdr_cid = w_rhead[CidLsb +: wh_cid_width_p];
  assign w_hdr_bad = (int'(w_hdr_cid) >= int'(num_in_p));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cid_err <= 1'b0;
    end else if ((r_rst == StRevIdle) && w_ryumi && w_hdr_bad) begin
      r_cid_err <= 1'b1;
    end
  end

  assign cid_err_o = r_cid_err;
`else
  assign w_hdr_bad = 1'b0;
  assign cid_err_o = 1'b0;
`endif

  // A dropped packet is consumed at full rate regardless of any pod-side ready.
  always_comb begin
    w_rst_nxt   = r_rst;
    w_rsel_nxt  = r_rsel;
    w_rdrop_nxt = r_rdrop;
    w_rcnt_nxt  = r_rcnt;
    w_rsel      = r_rsel;
    w_rbad      = r_rdrop;
    if (r_rst == StRevIdle) begin
      w_rsel = w_hdr_sel;
      w_rbad = w_hdr_bad;
    end
    w_rsel_ready = 1'b0;
    w_rev_v      = '0;
    for (int i = 0; i < num_in_p; i++) begin
      if (int'(w_rsel) == i) begin
        w_rsel_ready = w_in_ready_rev[i];
        w_rev_v[i]   = w_rhead_v & ~w_rbad;
      end
    end
    w_ryumi = w_rhead_v & (w_rbad | w_rsel_ready);
    unique case (r_rst)
      StRevIdle: begin
        if (w_ryumi && (w_hdr_len != '0)) begin
          w_rst_nxt   = StRevBusy;
          w_rsel_nxt  = w_hdr_sel;
          w_rdrop_nxt = w_hdr_bad;
          w_rcnt_nxt  = w_hdr_len;
        end
      end
      StRevBusy: begin
        if (w_ryumi) begin
          w_rcnt_nxt = r_rcnt - 1'b1;
          if (r_rcnt == LenW'(1)) w_rst_nxt = StRevIdle;
        end
      end
      default: w_rst_nxt = StRevIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rst   <= StRevIdle;
      r_rsel  <= '0;
      r_rdrop <= 1'b0;
      r_rcnt  <= '0;
    end else begin
      r_rst   <= w_rst_nxt;
      r_rsel  <= w_rsel_nxt;
      r_rdrop <= w_rdrop_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------------------------
  for (genvar i = 0; i < num_in_p; i++) begin : g_pack
    assign in_link_sif_o[i*LinkW +: LinkW] = {w_rev_v[i], w_fready[i], w_rhead};
  end

  assign out_link_sif_o = {w_out_v, w_rready, w_out_data};

endmodule
